// File: rtl/core_cache_bus_arbiter.sv
// Two-port cache refill bus arbiter: grants whole burst transactions (address,
// data, response) to icache (port 0) or dcache (port 1) over one downstream bus.
module core_cache_bus_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int DCACHE_PRIORITY = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [1:0]                            m_req_valid_i,
    output logic [1:0]                            m_req_ready_o,
    input  logic [1:0][ADDR_WIDTH-1:0]            m_req_addr_i,
    input  logic [1:0]                            m_req_write_i,
    input  logic [1:0][LEN_WIDTH-1:0]             m_req_len_i,
    input  logic [1:0]                            m_wvalid_i,
    output logic [1:0]                            m_wready_o,
    input  logic [1:0][DATA_WIDTH-1:0]            m_wdata_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]          m_wstrb_i,
    output logic [1:0]                            m_rvalid_o,
    output logic [1:0]                            m_rlast_o,
    output logic [DATA_WIDTH-1:0]                 m_rdata_o,
    output logic [1:0]                            m_bvalid_o,
    output logic                                  s_req_valid_o,
    input  logic                                  s_req_ready_i,
    output logic [ADDR_WIDTH-1:0]                 s_req_addr_o,
    output logic                                  s_req_write_o,
    output logic [LEN_WIDTH-1:0]                  s_req_len_o,
    output logic                                  s_wvalid_o,
    input  logic                                  s_wready_i,
    output logic [DATA_WIDTH-1:0]                 s_wdata_o,
    output logic [DATA_WIDTH/8-1:0]               s_wstrb_o,
    output logic                                  s_wlast_o,
    input  logic                                  s_rvalid_i,
    input  logic                                  s_rlast_i,
    input  logic [DATA_WIDTH-1:0]                 s_rdata_i,
    input  logic                                  s_bvalid_i,
    output logic [1:0]                            grant_o,
    output logic                                  busy_o,
    output logic                                  protocol_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WRESP,
        S_RDATA
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_owner;
    logic                 r_last_grant;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic                 r_err;
    logic                 w_sel;
    logic                 w_cnt_zero;
    logic                 w_whs;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_whs      = m_wvalid_i[r_owner] & s_wready_i;

    // Tie-break: fixed dcache priority, otherwise the port not granted last.
    always_comb begin
        if (m_req_valid_i == 2'b11) begin
            w_sel = (DCACHE_PRIORITY != 0) ? 1'b1 : ~r_last_grant;
        end else begin
            w_sel = m_req_valid_i[1];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|m_req_valid_i) w_next = S_ADDR;
            S_ADDR:  if (s_req_ready_i) w_next = m_req_write_i[r_owner] ? S_WDATA : S_RDATA;
            S_WDATA: if (w_whs && w_cnt_zero) w_next = S_WRESP;
            S_WRESP: if (s_bvalid_i) w_next = S_IDLE;
            S_RDATA: if (s_rvalid_i && s_rlast_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (|m_req_valid_i) r_owner <= w_sel;
                end
                S_ADDR: begin
                    if (s_req_ready_i) begin
                        r_last_grant <= r_owner;
                        r_cnt        <= m_req_len_i[r_owner];
                    end
                end
                S_WDATA: begin
                    if (w_whs && !w_cnt_zero) r_cnt <= r_cnt - 1'b1;
                end
                S_RDATA: begin
                    // Counter saturates at zero; a surplus beat is flagged, not wrapped.
                    if (s_rvalid_i) begin
                        if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
                        if (s_rlast_i != w_cnt_zero) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_req_ready_o  = '0;
        m_wready_o     = '0;
        m_rvalid_o     = '0;
        m_rlast_o      = '0;
        m_rdata_o      = '0;
        m_bvalid_o     = '0;
        s_req_valid_o  = 1'b0;
        s_req_addr_o   = '0;
        s_req_write_o  = 1'b0;
        s_req_len_o    = '0;
        s_wvalid_o     = 1'b0;
        s_wdata_o      = '0;
        s_wstrb_o      = '0;
        s_wlast_o      = 1'b0;
        grant_o        = '0;
        busy_o         = (r_state != S_IDLE);
        protocol_err_o = r_err;
        if (r_state != S_IDLE) grant_o[r_owner] = 1'b1;
        case (r_state)
            S_ADDR: begin
                s_req_valid_o          = 1'b1;
                s_req_addr_o           = m_req_addr_i[r_owner];
                s_req_write_o          = m_req_write_i[r_owner];
                s_req_len_o            = m_req_len_i[r_owner];
                m_req_ready_o[r_owner] = s_req_ready_i;
            end
            S_WDATA: begin
                s_wvalid_o          = m_wvalid_i[r_owner];
                s_wdata_o           = m_wdata_i[r_owner];
                s_wstrb_o           = m_wstrb_i[r_owner];
                s_wlast_o           = w_cnt_zero;
                m_wready_o[r_owner] = s_wready_i;
            end
            S_WRESP: begin
                m_bvalid_o[r_owner] = s_bvalid_i;
            end
            S_RDATA: begin
                m_rvalid_o[r_owner] = s_rvalid_i;
                m_rlast_o[r_owner]  = s_rlast_i;
                m_rdata_o           = s_rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_core_cache_bus_arbiter.sv
// Directed bench for core_cache_bus_arbiter: round-robin (ua) and dcache-priority
// (ub) instances share all inputs; each scenario checks one of them after a reset.
module tb_core_cache_bus_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       m_req_valid;
    logic [1:0][31:0] m_req_addr;
    logic [1:0]       m_req_write;
    logic [1:0][7:0]  m_req_len;
    logic [1:0]       m_wvalid;
    logic [1:0][31:0] m_wdata;
    logic [1:0][3:0]  m_wstrb;
    logic             s_req_ready;
    logic             s_wready;
    logic             s_rvalid;
    logic             s_rlast;
    logic [31:0]      s_rdata;
    logic             s_bvalid;

    logic [1:0]  a_req_ready, a_wready, a_rvalid, a_rlast, a_bvalid, a_grant;
    logic [31:0] a_rdata, a_addr, a_wdata;
    logic        a_req_valid, a_write, a_wvalid, a_wlast, a_busy, a_err;
    logic [7:0]  a_len;
    logic [3:0]  a_wstrb;
    logic [1:0]  b_req_ready, b_wready, b_rvalid, b_rlast, b_bvalid, b_grant;
    logic [31:0] b_rdata, b_addr, b_wdata;
    logic        b_req_valid, b_write, b_wvalid, b_wlast, b_busy, b_err;
    logic [7:0]  b_len;
    logic [3:0]  b_wstrb;

    int checks;
    int errors;

    core_cache_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8), .DCACHE_PRIORITY(0)) ua (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid_i(m_req_valid), .m_req_ready_o(a_req_ready), .m_req_addr_i(m_req_addr),
        .m_req_write_i(m_req_write), .m_req_len_i(m_req_len), .m_wvalid_i(m_wvalid),
        .m_wready_o(a_wready), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_rvalid_o(a_rvalid), .m_rlast_o(a_rlast), .m_rdata_o(a_rdata), .m_bvalid_o(a_bvalid),
        .s_req_valid_o(a_req_valid), .s_req_ready_i(s_req_ready), .s_req_addr_o(a_addr),
        .s_req_write_o(a_write), .s_req_len_o(a_len), .s_wvalid_o(a_wvalid),
        .s_wready_i(s_wready), .s_wdata_o(a_wdata), .s_wstrb_o(a_wstrb), .s_wlast_o(a_wlast),
        .s_rvalid_i(s_rvalid), .s_rlast_i(s_rlast), .s_rdata_i(s_rdata), .s_bvalid_i(s_bvalid),
        .grant_o(a_grant), .busy_o(a_busy), .protocol_err_o(a_err)
    );

    core_cache_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8), .DCACHE_PRIORITY(1)) ub (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid_i(m_req_valid), .m_req_ready_o(b_req_ready), .m_req_addr_i(m_req_addr),
        .m_req_write_i(m_req_write), .m_req_len_i(m_req_len), .m_wvalid_i(m_wvalid),
        .m_wready_o(b_wready), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_rvalid_o(b_rvalid), .m_rlast_o(b_rlast), .m_rdata_o(b_rdata), .m_bvalid_o(b_bvalid),
        .s_req_valid_o(b_req_valid), .s_req_ready_i(s_req_ready), .s_req_addr_o(b_addr),
        .s_req_write_o(b_write), .s_req_len_o(b_len), .s_wvalid_o(b_wvalid),
        .s_wready_i(s_wready), .s_wdata_o(b_wdata), .s_wstrb_o(b_wstrb), .s_wlast_o(b_wlast),
        .s_rvalid_i(s_rvalid), .s_rlast_i(s_rlast), .s_rdata_i(s_rdata), .s_bvalid_i(s_bvalid),
        .grant_o(b_grant), .busy_o(b_busy), .protocol_err_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        m_req_valid = '0; m_req_addr = '0; m_req_write = '0; m_req_len = '0;
        m_wvalid = '0; m_wdata = '0; m_wstrb = '0;
        s_req_ready = 1'b0; s_wready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_rdata = '0; s_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        checks++; if ({a_grant, a_busy, a_err, a_req_valid, a_wvalid, a_wlast} !== 7'b0) begin errors++; $display("FAIL reset_outputs got %b required 0", {a_grant, a_busy, a_err, a_req_valid, a_wvalid, a_wlast}); end
        checks++; if ({a_req_ready, a_wready, a_rvalid, a_rlast, a_bvalid} !== 10'b0) begin errors++; $display("FAIL reset_mports got %b required 0", {a_req_ready, a_wready, a_rvalid, a_rlast, a_bvalid}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_basic();
        do_reset();
        @(negedge clk);
        m_req_valid = 2'b01; m_req_addr[0] = 32'h0000_1000; m_req_len[0] = 8'd3;
        #1;
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL rd_latency s_req_valid got %b required 0", a_req_valid); end
        @(negedge clk); #1;
        checks++; if ({a_req_valid, a_grant, a_req_ready} !== 5'b1_01_00) begin errors++; $display("FAIL rd_addr_phase got %b required 10100", {a_req_valid, a_grant, a_req_ready}); end
        checks++; if ({a_addr, a_len, a_write} !== {32'h0000_1000, 8'd3, 1'b0}) begin errors++; $display("FAIL rd_addr_fields got %h/%0d/%b required 00001000/3/0", a_addr, a_len, a_write); end
        @(negedge clk); #1;
        checks++; if ({a_req_valid, a_req_ready} !== 3'b1_00) begin errors++; $display("FAIL rd_addr_wait got %b required 100", {a_req_valid, a_req_ready}); end
        @(negedge clk);
        s_req_ready = 1'b1;
        #1;
        checks++; if (a_req_ready !== 2'b01) begin errors++; $display("FAIL rd_req_ready got %b required 01", a_req_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin s_req_ready = 1'b0; m_req_valid = 2'b00; end
            s_rvalid = 1'b1; s_rlast = (i == 3); s_rdata = 32'hD000_0000 + i;
            #1;
            checks++; if ({a_rvalid, a_rlast} !== {2'b01, 1'b0, (i == 3)}) begin errors++; $display("FAIL rd_beat%0d valid/last got %b required %b", i, {a_rvalid, a_rlast}, {2'b01, 1'b0, (i == 3)}); end
            checks++; if (a_rdata !== 32'hD000_0000 + i) begin errors++; $display("FAIL rd_beat%0d data got %h required %h", i, a_rdata, 32'hD000_0000 + i); end
        end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        checks++; if ({a_busy, a_grant, a_err} !== 4'b0) begin errors++; $display("FAIL rd_done busy/grant/err got %b required 0000", {a_busy, a_grant, a_err}); end
    endtask

    // One len=0 read round on ua (use_b=0) or ub (use_b=1); afterwards the
    // granted port drops its request and the other keeps it pending.
    task automatic arb_round(input logic [1:0] req, input logic [1:0] exp, input bit use_b, input int idx);
        logic [1:0] g, r;
        @(negedge clk);
        m_req_valid = req; m_req_len = '0; m_req_write = '0;
        @(negedge clk); #1;
        g = use_b ? b_grant : a_grant;
        checks++; if (g !== exp) begin errors++; $display("FAIL arb%0d_r%0d grant got %b required %b", use_b, idx, g, exp); end
        s_req_ready = 1'b1;
        #1;
        r = use_b ? b_req_ready : a_req_ready;
        checks++; if (r !== exp) begin errors++; $display("FAIL arb%0d_r%0d req_ready got %b required %b", use_b, idx, r, exp); end
        @(negedge clk);
        s_req_ready = 1'b0; m_req_valid = req & ~exp; s_rvalid = 1'b1; s_rlast = 1'b1;
        #1;
        r = use_b ? b_rvalid : a_rvalid;
        checks++; if (r !== exp) begin errors++; $display("FAIL arb%0d_r%0d rvalid got %b required %b", use_b, idx, r, exp); end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        g = use_b ? b_grant : a_grant;
        checks++; if (g !== 2'b00) begin errors++; $display("FAIL arb%0d_r%0d idle_bubble grant got %b required 00", use_b, idx, g); end
    endtask

    task automatic test_round_robin();
        do_reset();
        arb_round(2'b11, 2'b01, 1'b0, 0);
        arb_round(2'b10, 2'b10, 1'b0, 1);
        arb_round(2'b11, 2'b01, 1'b0, 2);
    endtask

    task automatic test_dcache_priority();
        do_reset();
        arb_round(2'b11, 2'b10, 1'b1, 0);
        arb_round(2'b01, 2'b01, 1'b1, 1);
        arb_round(2'b11, 2'b10, 1'b1, 2);
    endtask

    task automatic test_write();
        do_reset();
        @(negedge clk);
        m_req_valid = 2'b10; m_req_write[1] = 1'b1; m_req_len[1] = 8'd1; m_req_addr[1] = 32'hCAFE_0040;
        @(negedge clk); #1;
        checks++; if ({a_write, a_len, a_addr, a_grant} !== {1'b1, 8'd1, 32'hCAFE_0040, 2'b10}) begin errors++; $display("FAIL wr_addr got %b/%0d/%h/%b required 1/1/cafe0040/10", a_write, a_len, a_addr, a_grant); end
        s_req_ready = 1'b1;
        @(negedge clk);
        s_req_ready = 1'b0; m_req_valid = 2'b00;
        m_wvalid = 2'b10; m_wdata[1] = 32'hAAAA_0001; m_wstrb[1] = 4'hF; s_wready = 1'b1;
        #1;
        checks++; if ({a_wvalid, a_wlast, a_wready, a_wdata, a_wstrb} !== {1'b1, 1'b0, 2'b10, 32'hAAAA_0001, 4'hF}) begin errors++; $display("FAIL wr_beat0 got %b/%b/%b/%h/%h required 1/0/10/aaaa0001/f", a_wvalid, a_wlast, a_wready, a_wdata, a_wstrb); end
        @(negedge clk);
        m_wdata[1] = 32'hBBBB_0002; m_wstrb[1] = 4'h3; s_wready = 1'b0;
        #1;
        checks++; if ({a_wvalid, a_wlast, a_wready} !== 4'b1_1_00) begin errors++; $display("FAIL wr_stall got %b required 1100", {a_wvalid, a_wlast, a_wready}); end
        @(negedge clk);
        s_wready = 1'b1;
        #1;
        checks++; if ({a_wlast, a_wready, a_wdata, a_wstrb} !== {1'b1, 2'b10, 32'hBBBB_0002, 4'h3}) begin errors++; $display("FAIL wr_beat1 got %b/%b/%h/%h required 1/10/bbbb0002/3", a_wlast, a_wready, a_wdata, a_wstrb); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++; if ({a_wvalid, a_wready, a_bvalid, a_busy} !== 6'b0_00_00_1) begin errors++; $display("FAIL wr_resp_wait%0d got %b required 000001", i, {a_wvalid, a_wready, a_bvalid, a_busy}); end
        end
        @(negedge clk);
        m_wvalid = 2'b00; s_wready = 1'b0; s_bvalid = 1'b1;
        #1;
        checks++; if (a_bvalid !== 2'b10) begin errors++; $display("FAIL wr_bvalid got %b required 10", a_bvalid); end
        @(negedge clk);
        s_bvalid = 1'b0;
        #1;
        checks++; if ({a_bvalid, a_busy} !== 3'b00_0) begin errors++; $display("FAIL wr_done got %b required 000", {a_bvalid, a_busy}); end
    endtask

    task automatic test_early_rlast();
        do_reset();
        @(negedge clk);
        m_req_valid = 2'b01; m_req_len[0] = 8'd3;
        @(negedge clk);
        s_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_req_ready = 1'b0; m_req_valid = 2'b00;
            s_rvalid = 1'b1; s_rlast = (i == 1);
        end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        checks++; if ({a_busy, a_err} !== 2'b01) begin errors++; $display("FAIL early_rlast busy/err got %b required 01", {a_busy, a_err}); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b required 1", a_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b required 0", a_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(negedge clk);
        m_req_valid = 2'b01; m_req_len[0] = 8'd3;
        @(negedge clk);
        s_req_ready = 1'b1;
        @(negedge clk);
        s_req_ready = 1'b0; m_req_valid = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h1111_1111;
        @(negedge clk);
        s_rdata = 32'h2222_2222;
        #1;
        checks++; if (a_rvalid !== 2'b01) begin errors++; $display("FAIL rst_mid_beat2 got %b required 01", a_rvalid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({a_busy, a_grant, a_rvalid, a_rlast, a_rdata} !== 39'b0) begin errors++; $display("FAIL rst_mid_outputs got %b/%b/%b/%b/%h required all 0", a_busy, a_grant, a_rvalid, a_rlast, a_rdata); end
        @(negedge clk);
        s_rvalid = 1'b0;
        rst_n = 1'b1;
        arb_round(2'b01, 2'b01, 1'b0, 9);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_read_basic();
        test_round_robin();
        test_dcache_priority();
        test_write();
        test_early_rlast();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
